// File: rtl/gray_bin_conv_pipe.sv
// Elastic valid/ready Gray<->binary converter; optional conv_cnt port under CONV_CNT_EN.
// Latency: STAGES cycles in either mode; one word per cycle when unstalled.
// Backpressure: combinational ready chain; a stalled output holds and upstream stages fill before in_ready drops.
module gray_bin_conv_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_mode,
    output logic [N-1:0] out_data
`ifdef CONV_CNT_EN
    ,
    output logic [15:0]  conv_cnt
`endif
);

    localparam int SEG = (N + STAGES - 1) / STAGES;

    // Stage s resolves Gray bits [N-1-s*SEG : N-(s+1)*SEG]; bits above are already binary.
    function automatic logic [N-1:0] stage_conv(input logic [N-1:0] w, input logic mode, input int s);
        logic [N-1:0] r;
        logic         c;
        r = w;
        c = 1'b0;
        if (mode) begin
            if (s == 0)
                r = w ^ (w >> 1);
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i <= N - 1 - s * SEG && i >= N - (s + 1) * SEG)
                    r[i] = w[i] ^ c;
                c = r[i];
            end
        end
        return r;
    endfunction

    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_rdy;
    logic [STAGES-1:0] stg_mode;
    logic [N-1:0]      stg_dat [STAGES];

    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_mode;
    logic [N-1:0]      src_dat [STAGES];

    always_comb begin
        logic chain;
        chain   = out_ready;
        stg_rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain      = !stg_vld[k] || chain;
            stg_rdy[k] = chain;
        end
    end

    always_comb begin
        src_vld[0]  = in_valid;
        src_mode[0] = in_mode;
        src_dat[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k]  = stg_vld[k-1];
            src_mode[k] = stg_mode[k-1];
            src_dat[k]  = stg_dat[k-1];
        end
    end

    assign in_ready = stg_rdy[0] && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
        end else if (flush) begin
            stg_vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stg_rdy[k])
                    stg_vld[k] <= src_vld[k];
            end
        end
    end

    // Payload needs no reset: the output is gated by the last valid bit.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (stg_rdy[k] && src_vld[k]) begin
                stg_dat[k]  <= stage_conv(src_dat[k], src_mode[k], k);
                stg_mode[k] <= src_mode[k];
            end
        end
    end

    assign out_valid = stg_vld[STAGES-1];
    assign out_mode  = stg_mode[STAGES-1] & out_valid;
    assign out_data  = stg_dat[STAGES-1] & {N{out_valid}};

`ifdef CONV_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conv_cnt <= 16'd0;
        else if (flush)
            conv_cnt <= 16'd0;
        else if (out_valid && out_ready && conv_cnt != 16'hFFFF)
            conv_cnt <= conv_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe: STAGES=2 instance for protocol tests,
// STAGES 1/3/8 instances for exhaustive round-trip.
module tb_gray_bin_conv_pipe;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_mode, out_ready;
    logic [7:0] d2, d1, d3, d8;
    logic       ir2, ov2, om2, ir1, ov1, om1, ir3, ov3, om3, ir8, ov8, om8;
    logic [7:0] od2, od1, od3, od8;
    logic [7:0] cap1, cap3, cap8;
`ifdef CONV_CNT_EN
    logic [15:0] cnt2, cnt1, cnt3, cnt8;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    gray_bin_conv_pipe #(.N(8), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .in_mode(in_mode), .in_data(d2), .out_valid(ov2), .out_ready(out_ready),
        .out_mode(om2), .out_data(od2)
`ifdef CONV_CNT_EN
        , .conv_cnt(cnt2)
`endif
    );
    gray_bin_conv_pipe #(.N(8), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_mode(in_mode), .in_data(d1), .out_valid(ov1), .out_ready(out_ready),
        .out_mode(om1), .out_data(od1)
`ifdef CONV_CNT_EN
        , .conv_cnt(cnt1)
`endif
    );
    gray_bin_conv_pipe #(.N(8), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .in_mode(in_mode), .in_data(d3), .out_valid(ov3), .out_ready(out_ready),
        .out_mode(om3), .out_data(od3)
`ifdef CONV_CNT_EN
        , .conv_cnt(cnt3)
`endif
    );
    gray_bin_conv_pipe #(.N(8), .STAGES(8)) u8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
        .in_mode(in_mode), .in_data(d8), .out_valid(ov8), .out_ready(out_ready),
        .out_mode(om8), .out_data(od8)
`ifdef CONV_CNT_EN
        , .conv_cnt(cnt8)
`endif
    );

    always @(posedge clk) begin
        if (ov1 && out_ready) cap1 <= od1;
        if (ov3 && out_ready) cap3 <= od3;
        if (ov8 && out_ready) cap8 <= od8;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        d1 = '0; d2 = '0; d3 = '0; d8 = '0;
        repeat (2) tick();
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", ov2); end
        vectors++; if (od2 !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h want 00", od2); end
        vectors++; if (om2 !== 1'b0) begin errors++; $display("FAIL reset out_mode: got %b want 0", om2); end
        vectors++; if (ir2 !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", ir2); end
`ifdef CONV_CNT_EN
        vectors++; if (cnt2 !== 16'd0) begin errors++; $display("FAIL reset conv_cnt: got %0d want 0", cnt2); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_g2b;
        logic [7:0] gin [2];
        logic [7:0] bexp [2];
        gin[0] = 8'hC0; bexp[0] = 8'h80;
        gin[1] = 8'h80; bexp[1] = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; d2 = gin[i];
            #1;
            vectors++; if (ir2 !== 1'b1) begin errors++; $display("FAIL g2b in_ready[%0d]: got %b want 1", i, ir2); end
            tick();
            in_valid = 1'b0;
            vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL g2b early out_valid[%0d]: got %b want 0", i, ov2); end
            tick();
            vectors++; if (ov2 !== 1'b1) begin errors++; $display("FAIL g2b out_valid[%0d]: got %b want 1", i, ov2); end
            vectors++; if (od2 !== bexp[i]) begin errors++; $display("FAIL g2b data[%0d]: got %h want %h", i, od2, bexp[i]); end
            vectors++; if (om2 !== 1'b0) begin errors++; $display("FAIL g2b mode[%0d]: got %b want 0", i, om2); end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic       mo [3];
        logic [7:0] din [3];
        logic [7:0] dexp [3];
        mo[0] = 1'b1; din[0] = 8'hFF; dexp[0] = 8'h80;
        mo[1] = 1'b1; din[1] = 8'h05; dexp[1] = 8'h07;
        mo[2] = 1'b0; din[2] = 8'h07; dexp[2] = 8'h05;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = mo[i]; d2 = din[i];
            #1;
            vectors++; if (ir2 !== 1'b1) begin errors++; $display("FAIL b2b in_ready[%0d]: got %b want 1", i, ir2); end
            tick();
            if (i >= 1) begin
                vectors++;
                if (ov2 !== 1'b1 || od2 !== dexp[i-1] || om2 !== mo[i-1]) begin
                    errors++; $display("FAIL b2b out[%0d]: got v=%b d=%h m=%b want v=1 d=%h m=%b", i-1, ov2, od2, om2, dexp[i-1], mo[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (ov2 !== 1'b1 || od2 !== dexp[2] || om2 !== mo[2]) begin
            errors++; $display("FAIL b2b out[2]: got v=%b d=%h m=%b want v=1 d=%h m=%b", ov2, od2, om2, dexp[2], mo[2]);
        end
        tick();
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL b2b drained out_valid: got %b want 0", ov2); end
    endtask

    task automatic test_backpressure;
        logic [7:0] words [3];
        logic [7:0] wexp [3];
        logic       rdy_exp [5];
        int         acc;
        words[0] = 8'h10; wexp[0] = 8'h18;
        words[1] = 8'h20; wexp[1] = 8'h30;
        words[2] = 8'h30; wexp[2] = 8'h28;
        rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b1; rdy_exp[2] = 1'b0; rdy_exp[3] = 1'b0; rdy_exp[4] = 1'b0;
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            d2 = words[acc];
            #1;
            vectors++; if (ir2 !== rdy_exp[c]) begin errors++; $display("FAIL bp in_ready[%0d]: got %b want %b", c, ir2, rdy_exp[c]); end
            if (ir2) acc++;
            tick();
            if (c >= 1) begin
                vectors++; if (ov2 !== 1'b1 || od2 !== wexp[0]) begin errors++; $display("FAIL bp hold[%0d]: got v=%b d=%h want v=1 d=%h", c, ov2, od2, wexp[0]); end
            end
        end
        vectors++; if (acc != 2) begin errors++; $display("FAIL bp accepted: got %0d want 2", acc); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (ov2 !== 1'b1 || od2 !== wexp[i]) begin errors++; $display("FAIL bp drain[%0d]: got v=%b d=%h want v=1 d=%h", i, ov2, od2, wexp[i]); end
            tick();
        end
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL bp dup: got out_valid %b want 0", ov2); end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b1;
        d2 = 8'h01; tick();
        d2 = 8'h02; tick();
        in_valid = 1'b0;
        vectors++; if (ov2 !== 1'b1) begin errors++; $display("FAIL mid pre-reset out_valid: got %b want 1", ov2); end
        #3 rst = 1'b1;
        #1;
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL mid async out_valid: got %b want 0", ov2); end
        vectors++; if (od2 !== 8'h00) begin errors++; $display("FAIL mid async out_data: got %h want 00", od2); end
        #1 rst = 1'b0;
        tick();
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL mid stale word: got out_valid %b want 0", ov2); end
        in_valid = 1'b1; d2 = 8'h04;
        tick();
        in_valid = 1'b0;
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL mid post early: got out_valid %b want 0", ov2); end
        tick();
        vectors++; if (ov2 !== 1'b1 || od2 !== 8'h06) begin errors++; $display("FAIL mid post first: got v=%b d=%h want v=1 d=06", ov2, od2); end
        tick();
    endtask

    task automatic test_flush;
        logic [7:0] gin [3];
        logic [7:0] bexp [3];
        gin[0] = 8'h03; bexp[0] = 8'h02;
        gin[1] = 8'h0F; bexp[1] = 8'h0A;
        gin[2] = 8'hFF; bexp[2] = 8'hAA;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1;
        d2 = 8'h11; tick();
        d2 = 8'h22; tick();
        d2 = 8'h33; #1;
        vectors++; if (ir2 !== 1'b0) begin errors++; $display("FAIL flush full in_ready: got %b want 0", ir2); end
        flush = 1'b1; #1;
        vectors++; if (ir2 !== 1'b0) begin errors++; $display("FAIL flush cycle in_ready: got %b want 0", ir2); end
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b want 0", ov2); end
        vectors++; if (ir2 !== 1'b1) begin errors++; $display("FAIL flush in_ready after: got %b want 1", ir2); end
`ifdef CONV_CNT_EN
        vectors++; if (cnt2 !== 16'd0) begin errors++; $display("FAIL flush conv_cnt: got %0d want 0", cnt2); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 1'b0; d2 = gin[i];
            tick();
            if (i >= 1) begin
                vectors++; if (ov2 !== 1'b1 || od2 !== bexp[i-1]) begin errors++; $display("FAIL flush post[%0d]: got v=%b d=%h want v=1 d=%h", i-1, ov2, od2, bexp[i-1]); end
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (ov2 !== 1'b1 || od2 !== bexp[2]) begin errors++; $display("FAIL flush post[2]: got v=%b d=%h want v=1 d=%h", ov2, od2, bexp[2]); end
        tick();
`ifdef CONV_CNT_EN
        vectors++; if (cnt2 !== 16'd3) begin errors++; $display("FAIL conv_cnt after 3: got %0d want 3", cnt2); end
`endif
        // flush wins over a valid input into an empty pipe
        in_valid = 1'b1; in_mode = 1'b0; d2 = 8'h55; flush = 1'b1; #1;
        vectors++; if (ir2 !== 1'b0) begin errors++; $display("FAIL flush empty in_ready: got %b want 0", ir2); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if (ov2 !== 1'b0) begin errors++; $display("FAIL flush swallowed[%0d]: got out_valid %b want 0", c, ov2); end
            tick();
        end
    endtask

    task automatic test_roundtrip;
        logic [7:0] v, g;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            g = v ^ (v >> 1);
            in_valid = 1'b1; in_mode = 1'b1; d1 = v; d3 = v; d8 = v;
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
            vectors++; if (cap1 !== g || cap3 !== g || cap8 !== g) begin errors++; $display("FAIL rt b2g %h: got s1=%h s3=%h s8=%h want %h", v, cap1, cap3, cap8, g); end
            in_valid = 1'b1; in_mode = 1'b0; d1 = cap1; d3 = cap3; d8 = cap8;
            tick();
            in_valid = 1'b0;
            repeat (9) tick();
            vectors++; if (cap1 !== v || cap3 !== v || cap8 !== v) begin errors++; $display("FAIL rt g2b %h: got s1=%h s3=%h s8=%h want %h", v, cap1, cap3, cap8, v); end
        end
    endtask

    initial begin
        test_reset();
        test_g2b();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_flush();
        test_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshake on both sides.
- Each transfer carries a mode bit selecting the direction: Gray->binary, or binary->Gray.
- The long Gray->binary XOR prefix chain is split across STAGES register stages, so wide counters (CDC pointers, encoder positions) convert at full clock rate.
- Sits between Gray-coded pointer/position sources and binary arithmetic logic.

Parameters:
N, 8, data width in bits; legal range N >= 2.
STAGES, 2, pipeline depth = fixed latency in cycles; legal range 1 <= STAGES <= N.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous pipeline clear
in_valid  input  1  input word valid
in_ready  output  1  converter can accept input this cycle
in_mode  input  1  0 = Gray->binary, 1 = binary->Gray
in_data  input  N  word to convert
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts output
out_mode  output  1  mode bit carried with the word
out_data  output  N  converted word

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - Asserting rst clears every stage valid bit immediately.
  - out_valid = 0, out_data = 0, out_mode = 0.
  - In-flight words are discarded; no partial output is ever presented.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Elastic pipeline: stage k loads from stage k-1 when stage k is empty or stage k is advancing. The last stage advances on out_ready.
  - in_ready = !v1 || stage 1 advancing (combinational ready chain).
  - Throughput is one word per cycle with out_ready held high.
- Latency: a word accepted at cycle t appears with out_valid = 1 at cycle t+STAGES, given no stall.
- Backpressure: while out_valid && !out_ready, out_data and out_mode hold stable. Upstream stages fill, then in_ready drops. No word is lost or duplicated.
- Gray->binary (mode 0): bin[N-1] = g[N-1]; bin[i] = g[i] ^ bin[i+1].
  - Bits are partitioned MSB-first into STAGES segments of SEG = ceil(N/STAGES) bits; the last segment may be shorter.
  - Stage s resolves segment s using the lowest resolved bit from stage s-1.
  - Unresolved Gray bits and the mode bit travel with the word.
- Binary->Gray (mode 1): gray = b ^ (b >> 1). Computed in stage 1, then carried through the remaining stages unchanged, so latency is identical for both modes.
- Mixed modes: consecutive words may differ in mode; each word keeps its own mode through the pipe. There are no bubbles on a mode change.
- flush: on a rising edge with flush = 1, all valid bits clear. in_ready = 0 during the flush cycle, so an input offered that cycle is not accepted. flush has priority over out_ready and in_valid.
- STAGES = 1: fully combinational conversion into a single output register.
- STAGES = N: one bit resolved per stage.
- Data registers need no reset; valid bits and output registers do.

Optional Feature:
Macro CONV_CNT_EN.
- Defined: adds output port conv_cnt [15:0], a saturating counter of completed output transfers.
  - Resets to 0 on rst or flush.
  - Increments on each out_valid && out_ready.
  - Holds at 16'hFFFF when saturated.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- N=8, STAGES=2, out_ready = 1:
  - mode 0, in_data 8'hC0 -> out_data 8'h80, out_mode 0, two cycles after acceptance.
  - mode 0, in_data 8'h80 -> out_data 8'hFF.
- Back-to-back mixed modes: mode 1 8'hFF, mode 1 8'h05, then mode 0 8'h07 on consecutive cycles -> outputs 8'h80, 8'h07, 8'h05 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready falls after 2 words are accepted; out_data holds. On out_ready = 1, words drain in order with no loss or duplicates.
- Exhaustive round-trip: N=8, STAGES in {1,3,8}, all 256 values in mode 1, with outputs fed back in mode 0 -> the original values return.
- rst asserted mid-stream, asynchronous and between edges, while 2 words are in flight -> out_valid falls immediately. After release, the first output is the first word accepted post-reset.
- flush with a full pipe and a stalled output -> next cycle out_valid = 0 and in_ready = 1. With CONV_CNT_EN defined, conv_cnt = 0 after flush and counts 3 after 3 completed transfers.
